// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: 3-byte register-access protocol on top of the uart FIFOs.
//   'W' addr data -> reg[addr] = data, reply 'K'
//   'R' addr      -> reply reg[addr]
//   anything else -> reply '?'
// Optional build macro UART_CMD_ECHO_EN: every popped byte is echoed to TX
// (through an extra S_ECHO state) before it is processed.
module uart_cmd_responder #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [7:0] reg0,
    output logic       busy,
    output logic       cmd_err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [7:0] OP_W    = 8'h57;
    localparam logic [7:0] OP_R    = 8'h52;
    localparam logic [7:0] RSP_K   = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_SEND = 3'd3
`ifdef UART_CMD_ECHO_EN
        , S_ECHO = 3'd4
`endif
    } state_t;

    state_t     state;
    logic       is_w;
    logic [7:0] addr_q;
    logic [7:0] regs [DEPTH];

    logic       fetch;
    logic       take;
    state_t     phase;
    logic [7:0] byte_in;
    state_t     nxt;
    logic [7:0] resp;
    logic       resp_err;
    logic       do_wr;

    // Full 8-bit comparison: out-of-range addresses never alias onto a register.
    function automatic logic in_range(input logic [7:0] a);
        return {1'b0, a} < 9'(DEPTH);
    endfunction

    assign fetch   = (state == S_OP) || (state == S_ADDR) || (state == S_DATA);
    assign rd_uart = reset && fetch && !rx_empty;
    assign busy    = (state != S_OP);
    assign reg0    = regs[0];

`ifdef UART_CMD_ECHO_EN
    state_t     ret_q;
    logic [7:0] echo_q;

    // The byte is processed once its echo has been accepted by the TX FIFO.
    assign take    = (state == S_ECHO) && !tx_full;
    assign phase   = ret_q;
    assign byte_in = echo_q;
    assign wr_uart = reset && !tx_full && ((state == S_SEND) || (state == S_ECHO));
`else
    // Without echo the byte is processed in the same cycle it is popped.
    assign take    = fetch && !rx_empty;
    assign phase   = state;
    assign byte_in = r_data;
    assign wr_uart = reset && !tx_full && (state == S_SEND);
`endif

    // Decode one protocol byte in the context of the fetch phase it belongs to.
    always_comb begin
        nxt      = S_OP;
        resp     = RSP_ERR;
        resp_err = 1'b0;
        do_wr    = 1'b0;
        case (phase)
            S_OP: begin
                if (byte_in == OP_W || byte_in == OP_R) begin
                    nxt = S_ADDR;
                end else begin
                    nxt      = S_SEND;
                    resp_err = 1'b1;
                end
            end
            S_ADDR: begin
                if (is_w) begin
                    nxt = S_DATA;
                end else begin
                    nxt = S_SEND;
                    if (in_range(byte_in)) resp = regs[byte_in[AW-1:0]];
                    else                   resp_err = 1'b1;
                end
            end
            S_DATA: begin
                nxt = S_SEND;
                if (in_range(addr_q)) begin
                    resp  = RSP_K;
                    do_wr = 1'b1;
                end else begin
                    resp_err = 1'b1;
                end
            end
            default: nxt = S_OP;
        endcase
    end

    // Command FSM, register file and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_OP;
            w_data  <= 8'h00;
            cmd_err <= 1'b0;
            is_w    <= 1'b0;
            addr_q  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
`ifdef UART_CMD_ECHO_EN
            ret_q   <= S_OP;
            echo_q  <= 8'h00;
`endif
        end else begin
            cmd_err <= 1'b0;
`ifdef UART_CMD_ECHO_EN
            if (fetch && !rx_empty) begin
                echo_q <= r_data;
                w_data <= r_data;
                ret_q  <= state;
                state  <= S_ECHO;
            end
`endif
            if (take) begin
                if (phase == S_OP)   is_w   <= (byte_in == OP_W);
                if (phase == S_ADDR) addr_q <= byte_in;
                if (do_wr)           regs[addr_q[AW-1:0]] <= byte_in;
                state <= nxt;
                if (nxt == S_SEND) begin
                    w_data  <= resp;
                    cmd_err <= resp_err;
                end
            end
            if (state == S_SEND && !tx_full) state <= S_OP;
        end
    end

endmodule
